// File: rtl/pwm_ramp.sv
// pwm_ramp: double-buffered pwm period/window with a soft-start ramp of the pulse end
module pwm_ramp #(
  parameter int WIDTH = 32,
  parameter int DIV_W = 16
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  sclr,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_per,
  input  logic [WIDTH-1:0]      cfg_t0,
  input  logic [WIDTH-1:0]      cfg_t1_start,
  input  logic [WIDTH-1:0]      cfg_t1_target,
  input  logic [WIDTH-1:0]      cfg_step,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic                  enable,
  input  logic                  load,
  output logic [WIDTH-1:0]      per,
  output logic [1:0][WIDTH-1:0] t,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;
  state_t state, state_nx;
  logic pend, hs, commit;
  logic [WIDTH-1:0] s_per, s_t0, s_start, s_target, s_step;
  logic [DIV_W-1:0] s_div;
  logic [WIDTH-1:0] c_target, c_start, c_t0;
  logic [WIDTH-1:0] t0, t1, target, step;
  logic [WIDTH-1:0] per_nx, t0_nx, t1_nx, target_nx, step_nx;
  logic [DIV_W-1:0] div, cnt, div_nx, cnt_nx;
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] up, dn, stepped, kept_t1;
  assign cfg_ready = !pend;
  assign hs = cfg_valid && !pend;
  assign commit = pend && enable && (state == IDLE || load);
  assign busy = state == RAMP;
  assign done = state == HOLD;
  assign t = {t1, t0};
  assign c_target = cfg_t1_target < cfg_per ? cfg_t1_target : cfg_per;
  assign c_start = cfg_t1_start < c_target ? cfg_t1_start : c_target;
  assign c_t0 = cfg_t0 < c_target ? cfg_t0 : c_target;
  assign sum = {1'b0, t1} + {1'b0, step};
  assign up = sum > {1'b0, target} ? target : sum[WIDTH-1:0];
  assign dn = (t1 < step || (t1 - step) < target) ? target : t1 - step;
  assign stepped = step == '0 ? target : t1 < target ? up : dn;
  assign kept_t1 = t1 > s_per ? s_target : t1;

  // shadow buffer: capture clamped settings on handshake, release on commit
  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) begin
      pend <= 1'b0;
      s_per <= '0;
      s_t0 <= '0;
      s_start <= '0;
      s_target <= '0;
      s_step <= '0;
      s_div <= '0;
    end else if (sclr) begin
      pend <= 1'b0;
    end else begin
      pend <= hs ? 1'b1 : commit ? 1'b0 : pend;
      if (hs) begin
        s_per <= cfg_per;
        s_t0 <= c_t0;
        s_start <= c_start;
        s_target <= c_target;
        s_step <= cfg_step;
        s_div <= cfg_div;
      end
    end

  // state and live settings register
  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) begin
      state <= IDLE;
      per <= '1;
      t0 <= '0;
      t1 <= '0;
      target <= '0;
      step <= '0;
      div <= '0;
      cnt <= '0;
    end else if (sclr) begin
      state <= IDLE;
      per <= '1;
      t0 <= '0;
      t1 <= '0;
      target <= '0;
      step <= '0;
      div <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      per <= per_nx;
      t0 <= t0_nx;
      t1 <= t1_nx;
      target <= target_nx;
      step <= step_nx;
      div <= div_nx;
      cnt <= cnt_nx;
    end

  // next state: idle commits at once, running states only move on the period boundary
  always_comb begin
    state_nx = state;
    per_nx = per;
    t0_nx = t0;
    t1_nx = t1;
    target_nx = target;
    step_nx = step;
    div_nx = div;
    cnt_nx = cnt;
    if (state == IDLE) begin
      if (commit) begin
        per_nx = s_per;
        t0_nx = s_t0;
        t1_nx = s_start;
        target_nx = s_target;
        step_nx = s_step;
        div_nx = s_div;
        cnt_nx = '0;
        state_nx = s_start == s_target ? HOLD : RAMP;
      end
    end else if (!enable) begin
      t1_nx = t0;
      state_nx = IDLE;
    end else if (commit) begin
      per_nx = s_per;
      t0_nx = s_t0;
      t1_nx = kept_t1;
      target_nx = s_target;
      step_nx = s_step;
      div_nx = s_div;
      cnt_nx = '0;
      state_nx = kept_t1 == s_target ? HOLD : RAMP;
    end else if (load && state == RAMP) begin
      if (cnt == div) begin
        cnt_nx = '0;
        t1_nx = stepped;
        state_nx = stepped == target ? HOLD : RAMP;
      end else begin
        cnt_nx = cnt + DIV_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_pwm_ramp.sv
// tb_pwm_ramp: directed checks of pwm_ramp against a cycle-level behavioural model
module tb_pwm_ramp;
  logic clk = 0, aclr_n = 1, sclr = 0, cfg_valid = 0, enable = 0, load = 0;
  logic cfg_ready, busy, done;
  logic [31:0] cfg_per = 0, cfg_t0 = 0, cfg_t1_start = 0, cfg_t1_target = 0, cfg_step = 0;
  logic [15:0] cfg_div = 0;
  logic [31:0] per;
  logic [1:0][31:0] t;
  int n_assert = 0, n_fail = 0;

  pwm_ramp dut (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_per(cfg_per), .cfg_t0(cfg_t0), .cfg_t1_start(cfg_t1_start), .cfg_t1_target(cfg_t1_target),
    .cfg_step(cfg_step), .cfg_div(cfg_div), .enable(enable), .load(load),
    .per(per), .t(t), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // model: 0 idle, 1 ramping, 2 holding
  bit [31:0] m_per = '1, m_t0 = 0, m_t1 = 0, m_tg = 0, m_step = 0;
  int m_div = 0, m_cnt = 0, m_mode = 0;
  bit m_pend = 0, m_hs;
  bit [31:0] s_per, s_t0, s_st, s_tg, s_step;
  int s_div;

  function automatic bit [31:0] umin(bit [31:0] a, bit [31:0] b);
    return a < b ? a : b;
  endfunction

  function automatic bit [31:0] toward(bit [31:0] cur, bit [31:0] tg, bit [31:0] st);
    longint c = cur, g = tg, s = st;
    if (s == 0) return tg;
    if (c < g) return (c + s > g) ? tg : 32'(c + s);
    return (c - s < g) ? tg : 32'(c - s);
  endfunction

  task automatic model_reset();
    m_per = '1; m_t0 = 0; m_t1 = 0; m_tg = 0; m_step = 0;
    m_div = 0; m_cnt = 0; m_mode = 0; m_pend = 0;
  endtask

  task automatic take_shadow();
    m_per = s_per; m_t0 = s_t0; m_tg = s_tg; m_step = s_step; m_div = s_div; m_cnt = 0; m_pend = 0;
  endtask

  // model update on every active edge, plus immediate async clear
  always @(posedge clk or negedge aclr_n) begin
    if (!aclr_n || sclr) model_reset();
    else begin
      m_hs = cfg_valid && !m_pend;
      if (m_mode == 0) begin
        if (enable && m_pend) begin
          take_shadow();
          m_t1 = s_st;
          m_mode = (m_t1 == m_tg) ? 2 : 1;
        end
      end else if (!enable) begin
        m_t1 = m_t0;
        m_mode = 0;
      end else if (load && m_pend) begin
        take_shadow();
        if (m_t1 > m_per) m_t1 = m_tg;
        m_mode = (m_t1 == m_tg) ? 2 : 1;
      end else if (load && m_mode == 1) begin
        if (m_cnt == m_div) begin
          m_cnt = 0;
          m_t1 = toward(m_t1, m_tg, m_step);
          if (m_t1 == m_tg) m_mode = 2;
        end else m_cnt++;
      end
      if (m_hs) begin
        s_tg = umin(cfg_t1_target, cfg_per);
        s_st = umin(cfg_t1_start, s_tg);
        s_t0 = umin(cfg_t0, s_tg);
        s_per = cfg_per; s_step = cfg_step; s_div = int'(cfg_div);
        m_pend = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("per_cyc", per, m_per);
    chk("t0_cyc", t[0], m_t0);
    chk("t1_cyc", t[1], m_t1);
    chk("busy_cyc", busy, m_mode == 1);
    chk("done_cyc", done, m_mode == 2);
    chk("ready_cyc", cfg_ready, !m_pend);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input int gap);
    repeat (gap) tick();
    load = 1;
    tick();
    load = 0;
  endtask

  task automatic send_cfg(input logic [31:0] p, t0v, st, tg, sp, input logic [15:0] dv);
    logic ok = 0;
    cfg_per = p; cfg_t0 = t0v; cfg_t1_start = st; cfg_t1_target = tg; cfg_step = sp; cfg_div = dv;
    cfg_valid = 1;
    for (int i = 0; i < 500 && !ok; i++) begin
      ok = cfg_ready;
      tick();
    end
    cfg_valid = 0;
    chk("cfg_handshake", ok, 1);
  endtask

  initial begin
    #1 aclr_n = 0;
    repeat (3) tick();
    aclr_n = 1;
    tick();
    // reset state and idle immunity to load
    chk("rst_per", per, 32'hFFFFFFFF);
    chk("rst_t", t, 64'h0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy_done", {busy, done}, 0);
    do_load(2);
    chk("idle_load_per", per, 32'hFFFFFFFF);
    chk("idle_load_t1", t[1], 0);
    // basic ramp 10..50 step 10 every 2nd load
    enable = 1;
    send_cfg(99, 0, 10, 50, 10, 1);
    tick();
    chk("ramp_first_t1", t[1], 10);
    chk("ramp_first_per", per, 99);
    chk("ramp_busy", busy, 1);
    do_load(10); do_load(10);
    chk("ramp_20", t[1], 20);
    do_load(10); do_load(10);
    chk("ramp_30", t[1], 30);
    do_load(10); do_load(10);
    chk("ramp_40", t[1], 40);
    do_load(10); do_load(10);
    chk("ramp_50", t[1], 50);
    chk("ramp_done", {busy, done}, 2'b01);
    // ramp down from hold, with a stalled second offer
    send_cfg(99, 0, 0, 25, 10, 0);
    cfg_valid = 1;
    tick(); tick();
    chk("stall_ready", cfg_ready, 0);
    chk("stall_t1", t[1], 50);
    do_load(3);
    chk("down_commit_t1", t[1], 50);
    chk("down_commit_busy", busy, 1);
    tick();
    cfg_valid = 0;
    chk("refill_ready", cfg_ready, 0);
    do_load(3);
    chk("down_recommit_t1", t[1], 50);
    do_load(3);
    chk("down_40", t[1], 40);
    do_load(3);
    chk("down_30", t[1], 30);
    do_load(3);
    chk("down_25", t[1], 25);
    chk("down_done", done, 1);
    // clamping at latch time
    enable = 0;
    tick();
    send_cfg(20, 25, 40, 30, 5, 0);
    enable = 1;
    tick();
    chk("clamp_per", per, 20);
    chk("clamp_t0", t[0], 20);
    chk("clamp_t1", t[1], 20);
    chk("clamp_hold", {busy, done}, 2'b01);
    // rising sum must not wrap
    enable = 0;
    tick();
    send_cfg(32'hFFFFFFFF, 0, 32'hFFFFFFE0, 32'hFFFFFFE0, 0, 0);
    enable = 1;
    tick();
    chk("wrap_setup_t1", t[1], 32'hFFFFFFE0);
    send_cfg(32'hFFFFFFFF, 0, 0, 32'hFFFFFFF0, 32'h20, 0);
    do_load(2);
    do_load(2);
    chk("nowrap_t1", t[1], 32'hFFFFFFF0);
    chk("nowrap_done", done, 1);
    // falling difference must saturate at target
    send_cfg(32'hFFFFFFFF, 0, 0, 16, 32'hFFFFFFF8, 0);
    do_load(2);
    do_load(2);
    chk("nounder_t1", t[1], 16);
    // enable drop mid-ramp, then re-enable with pending config
    enable = 0;
    tick();
    send_cfg(99, 0, 10, 50, 10, 0);
    enable = 1;
    tick();
    do_load(3);
    do_load(3);
    chk("mid_t1", t[1], 30);
    send_cfg(80, 5, 15, 40, 5, 0);
    chk("mid_pend_t1", t[1], 30);
    enable = 0;
    tick();
    chk("drop_t1", t[1], 0);
    chk("drop_busy", busy, 0);
    chk("drop_keeps_pend", cfg_ready, 0);
    enable = 1;
    tick();
    chk("reen_per", per, 80);
    chk("reen_t", t, {32'd15, 32'd5});
    chk("reen_busy", busy, 1);
    // async clear mid-ramp with pending config
    send_cfg(70, 0, 20, 60, 5, 0);
    aclr_n = 0;
    #1;
    chk("aclr_per", per, 32'hFFFFFFFF);
    chk("aclr_t", t, 64'h0);
    chk("aclr_ready", cfg_ready, 1);
    chk("aclr_busy", busy, 0);
    tick();
    aclr_n = 1;
    // sync clear in hold with pending config
    send_cfg(99, 0, 30, 30, 1, 0);
    tick();
    chk("pre_sclr_done", done, 1);
    chk("pre_sclr_t1", t[1], 30);
    send_cfg(99, 0, 1, 2, 1, 0);
    sclr = 1;
    tick();
    sclr = 0;
    chk("sclr_per", per, 32'hFFFFFFFF);
    chk("sclr_t", t, 64'h0);
    chk("sclr_ready", cfg_ready, 1);
    chk("sclr_flags", {busy, done}, 0);
    tick();
    chk("post_sclr_idle", {busy, done}, 0);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_ramp.md
Name: pwm_ramp

Overview:
Soft-start and parameter double-buffer stage directly upstream of the pwm generator. It drives the pwm period and the on-window bounds t[0]/t[1]. New settings from the register side are captured in a shadow buffer and committed only on the pwm period boundary (load), so the pwm never sees a torn or mid-period update. The pulse end t[1] ramps from a start value to a target in fixed steps, one step every N periods, which limits inrush on the generator.

Parameters:
WIDTH, 32, width of period and time values (matches pwm WIDTH)
DIV_W, 16, width of the periods-per-step divider

Ports:
clk  in  1  system clock
aclr_n  in  1  asynchronous reset, active low
sclr  in  1  synchronous clear; same effect as reset
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  shadow buffer free; handshake occurs when cfg_valid && cfg_ready
cfg_per  in  WIDTH  period value for pwm
cfg_t0  in  WIDTH  pulse start
cfg_t1_start  in  WIDTH  ramp start value of pulse end
cfg_t1_target  in  WIDTH  final pulse end
cfg_step  in  WIDTH  t[1] increment per ramp step; 0 = jump directly to target
cfg_div  in  DIV_W  ramp step every cfg_div+1 periods
enable  in  1  run request
load  in  1  period boundary pulse from pwm
per  out  WIDTH  to pwm per
t  out  [1:0][WIDTH-1:0]  to pwm t; t[0] = start, t[1] = end
busy  out  1  state == RAMP
done  out  1  state == HOLD

Behaviour:
- Reset and sclr values:
  - per = all ones; t[0] = 0; t[1] = 0; this gives an empty window, so pwm q stays inactive.
  - cfg_ready = 1; busy = 0; done = 0.
  - Shadow buffer empties and the divider clears to 0.
  - Reset or sclr mid-ramp aborts immediately. sclr has priority over every other input.
- Shadow buffer:
  - On handshake, latch all cfg_* and set pend = 1; cfg_ready = !pend.
  - Clamps applied at latch time:
    - target = min(cfg_t1_target, cfg_per)
    - start = min(cfg_t1_start, target)
    - t0 = min(cfg_t0, target)
- States: IDLE, RAMP, HOLD.
- IDLE:
  - Outputs hold their last per and t[0]; t[1] = t[0] (empty window).
  - If enable && pend, commit on the next cycle without waiting for load (pwm is free-running, so an empty window cannot glitch):
    - per, t[0] and t[1] = start are loaded.
    - pend clears and the divider clears.
    - Go to RAMP, or to HOLD if start == target.
- RAMP and HOLD: registered outputs change only in the cycle where load = 1, so new values are stable when the pwm counter restarts at 0.
- Commit during RAMP/HOLD: on load with pend = 1:
  - per, t[0] and target update; pend clears.
  - t[1] does not jump. It ramps from its current value toward the new target, in either direction.
  - Divider restarts at 0.
  - State becomes RAMP if t[1] != new target, otherwise HOLD.
  - If the current t[1] exceeds the new per, t[1] is clamped to the new target in the same cycle.
- Ramp step, on load in RAMP when pend = 0:
  - If div_cnt == cfg_div: div_cnt = 0 and t[1] moves toward target.
    - Rising: t[1] = min(t[1] + step, target), with the sum computed at WIDTH+1 bits (no wrap).
    - Falling: t[1] = max(t[1] - step, target), with underflow saturating at target.
    - step == 0: t[1] = target.
    - Reaching target moves the state to HOLD in the same cycle.
  - Otherwise div_cnt increments.
- load with pend = 1 takes priority over a ramp step in the same cycle.
- enable deassert in RAMP/HOLD: the next cycle sets t[1] = t[0] and the state goes to IDLE, not waiting for load (shortens the current pulse, never lengthens it). Pending configuration is kept.
- A handshake in the same cycle as a commit is accepted: cfg_ready is computed from registered pend, and the new data refills the buffer.
- Latencies:
  - Handshake to visible outputs: in IDLE, 2 cycles; otherwise the first load ≥1 cycle after the handshake.
  - enable fall to empty window: 1 cycle.

Test Plan:
1. Reset, then IDLE with enable = 0 → per = FFFFFFFF, t = {0,0}, cfg_ready = 1, busy = done = 0; no output change when load is pulsed.
2. cfg per = 99, t0 = 0, start = 10, target = 50, step = 10, div = 1, then enable = 1, with load every 100 cycles → t[1] = 10 two cycles after handshake, then 20, 30, 40, 50 every 2nd load; done = 1 at 50; busy = 0 after.
3. In HOLD at 50, new cfg target = 25, step = 10, div = 0 → outputs unchanged until the next load, then 40, 30, 25 on successive loads; never a jump to 25. A second cfg_valid is stalled (cfg_ready = 0) until the commit.
4. Clamping: per = 20, target = 30, start = 40, t0 = 25 → committed t[1] = 20, t[0] = 20, state HOLD immediately. Also target = FFFFFFF0, step = 20 from t[1] = FFFFFFE0 → t[1] = FFFFFFF0, with no wrap.
5. enable drops mid-RAMP (t[1] = 30, load not asserted) → next cycle t[1] = t[0], IDLE, busy = 0. Re-enable with a pending cfg → commits without waiting for load.
6. aclr_n low mid-RAMP with pend = 1, then sclr in HOLD → all outputs return to reset values immediately (async) or on the next edge (sclr); pend cleared; cfg_ready = 1.
